// File: rtl/lab_door_arbiter.sv
// Round-robin arbiter sharing one occupancy unit between the Mera and Digital
// door readers; issues one transaction at a time and drives door-open/deny.
module lab_door_arbiter #(
  parameter int unsigned UNLOCK_CYCLES = 4,
  parameter int unsigned RESP_TIMEOUT  = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       reqMera,
  input  logic [4:0] codeMera,
  input  logic       dirMera,
  output logic       ackMera,
  input  logic       reqDigital,
  input  logic [4:0] codeDigital,
  input  logic       dirDigital,
  output logic       ackDigital,
  output logic [4:0] occCode,
  output logic       occLab,
  output logic [1:0] occMode,
  input  logic       occDone,
  input  logic       occUnlock,
  output logic       doorOpenMera,
  output logic       doorOpenDigital,
  output logic       denyMera,
  output logic       denyDigital,
  output logic       busy
);

  localparam int unsigned TW = 8;
  localparam logic [TW-1:0] UNLOCK_LD = TW'(UNLOCK_CYCLES);
  localparam logic [TW-1:0] TMO_LAST  = TW'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10
  } state_t;

  state_t        r_state;
  logic          r_ptr;
  logic [TW-1:0] r_cnt;
  logic [4:0]    r_code;
  logic          r_lab;
  logic [1:0]    r_mode;
  logic          r_deny_mera;
  logic          r_deny_dig;
  logic [TW-1:0] r_timer_mera;
  logic [TW-1:0] r_timer_dig;

  logic w_idle;
  logic w_grant_mera;
  logic w_grant_dig;
  logic w_dir;
  logic w_done_ok;
  logic w_open_mera;
  logic w_open_dig;

  // r_ptr = 0 gives Mera priority on a tie, 1 gives Digital priority
  assign w_idle       = (r_state == S_IDLE) && !RST;
  assign w_grant_mera = w_idle && reqMera && (!reqDigital || !r_ptr);
  assign w_grant_dig  = w_idle && reqDigital && (!reqMera || r_ptr);
  assign w_dir        = w_grant_mera ? dirMera : dirDigital;
  assign w_done_ok    = (r_state == S_WAIT) && occDone && occUnlock;
  assign w_open_mera  = w_done_ok && !r_lab;
  assign w_open_dig   = w_done_ok && r_lab;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_ptr       <= 1'b0;
      r_cnt       <= '0;
      r_code      <= '0;
      r_lab       <= 1'b0;
      r_mode      <= 2'b00;
      r_deny_mera <= 1'b0;
      r_deny_dig  <= 1'b0;
    end else begin
      r_deny_mera <= 1'b0;
      r_deny_dig  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_mera || w_grant_dig) begin
            r_code  <= w_grant_mera ? codeMera : codeDigital;
            r_lab   <= w_grant_dig;
            r_mode  <= w_dir ? 2'b01 : 2'b10;
            r_ptr   <= w_grant_mera;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_mode  <= 2'b00;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + TW'(1);
          if (occDone) begin
            if (!occUnlock) begin
              r_deny_mera <= !r_lab;
              r_deny_dig  <= r_lab;
            end
            r_state <= S_IDLE;
          end else if (r_cnt == TMO_LAST) begin
            r_deny_mera <= !r_lab;
            r_deny_dig  <= r_lab;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Door timers run independently of the FSM; a grant reloads, never adds
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_timer_mera <= '0;
      r_timer_dig  <= '0;
    end else begin
      if (w_open_mera)
        r_timer_mera <= UNLOCK_LD;
      else if (r_timer_mera != '0)
        r_timer_mera <= r_timer_mera - TW'(1);
      if (w_open_dig)
        r_timer_dig <= UNLOCK_LD;
      else if (r_timer_dig != '0)
        r_timer_dig <= r_timer_dig - TW'(1);
    end
  end

  assign ackMera         = w_grant_mera;
  assign ackDigital      = w_grant_dig;
  assign occCode         = r_code;
  assign occLab          = r_lab;
  assign occMode         = r_mode;
  assign denyMera        = r_deny_mera;
  assign denyDigital     = r_deny_dig;
  assign doorOpenMera    = (r_timer_mera != '0);
  assign doorOpenDigital = (r_timer_dig != '0);
  assign busy            = (r_state != S_IDLE);

endmodule
